irq_dispatch_seq: RTL
=====================

// Module: irq_dispatch_seq
// PURPOSE
//  Sequences SM83 interrupt dispatch through the register file write ports and the bus.
//  At an instruction boundary with IME set and an enabled request pending, it pushes PC,
//  then loads the vector into PC. It also clears the serviced IF bit and IME.
//  Sits beside the core control FSM and muxes onto the PC/SP write enables while busy.
// PARAMETERS
//  N_IRQ       5        number of interrupt sources (IF/IE bits used)
//  VEC_BASE    16'h0040 vector of source 0
//  VEC_STRIDE  8        vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE
// PORTS
//  clk        in   1      core clock
//  rst        in   1      synchronous, active-high reset
//  boundary   in   1      pulse: control FSM at instruction boundary, may be preempted
//  ime        in   1      interrupt master enable
//  ie_q       in   N_IRQ  IE register bits
//  if_q       in   N_IRQ  IF register bits
//  r_pc       in   16     current PC from register file
//  r_sp       in   16     current SP from register file
//  busy       out  1      dispatch in progress; control FSM stalls, yields PC/SP ports
//  wake       out  1      comb: |(ie_q & if_q), HALT exit regardless of ime
//  ime_clr    out  1      one-cycle pulse on accept
//  if_clr     out  N_IRQ  one-hot one-cycle pulse clearing serviced IF bit
//  wen_pc     out  1      PC write enable;  w_pc out 16 PC write data
//  wen_sp     out  1      SP write enable;  w_sp out 16 SP write data
//  mem_req    out  1      bus write request, held until mem_ack
//  mem_addr   out  16     bus write address
//  mem_wdata  out  8      bus write data
//  mem_ack    in   1      bus write accepted this cycle
//  done       out  1      one-cycle pulse in JUMP
// BEHAVIOUR
//  Reset: state IDLE; every registered output 0 (busy, ime_clr, if_clr, wen_*, mem_req,
//   done); latched index 0. Reset mid-dispatch aborts at once: no further writes, IF kept.
//  pend = ie_q & if_q; idx = lowest set bit of pend (bit 0 highest priority).
//  IDLE:  boundary & ime & |pend -> WAIT0; latch idx, pc_q=r_pc; ime_clr=1 that edge.
//         boundary with ime=0 or pend=0 -> stay IDLE, no outputs.
//  WAIT0 -> WAIT1 -> PUSH_HI: one clk each, internal delay only.
//  PUSH_HI: mem_req=1, mem_addr=r_sp-1, mem_wdata=pc_q[15:8]; on mem_ack: wen_sp=1,
//         w_sp=r_sp-1, -> PUSH_LO. Without mem_ack: hold, all outputs stable.
//  PUSH_LO: mem_req=1, mem_addr=r_sp-1, mem_wdata=pc_q[7:0]; on mem_ack: wen_sp=1,
//         w_sp=r_sp-1, -> JUMP.
//  JUMP:  wen_pc=1, w_pc=vector(idx); if_clr[idx]=1; done=1; -> IDLE.
//  Total latency: accept to done = 5 clks with zero-wait bus.
//  busy=1 in every state except IDLE. Exactly one wen_* or if_clr pulse per event.
//  SP arithmetic is 16-bit modulo: SP=0x0000 pushes to 0xFFFF, then 0xFFFE.
//  IF bits rising after accept do not change idx (unless quirk enabled).
//  boundary pulses while busy are ignored.
// CONFIGURATION
//  IRQ_CANCEL_QUIRK_EN defined: on PUSH_HI mem_ack, re-sample pend one clk later (after
//   the IE write has landed) and recompute idx. If pend==0, JUMP writes w_pc=16'h0000 and
//   pulses no if_clr. This matches the hardware push-into-IE cancellation.
//  Undefined: idx fixed at accept; vector always vector(idx latched at accept).
// STRUCTURE
//  sm83_pkg: irq_state_t enum (IDLE,WAIT0,WAIT1,PUSH_HI,PUSH_LO,JUMP), IRQ_VBLANK..
//   IRQ_JOYPAD index constants, N_IRQ_DEF, IRQ_VEC_BASE.
//  Sub-module: irq_prio_enc, a combinational lowest-set-bit encoder (valid + index),
//   shared with the HALT logic.
// TESTING
//  1 ime=1, ie=0x1F, if=0x04, PC=0x1234, SP=0xFFFE, boundary -> 0xFFFD<=0x12,
//    0xFFFC<=0x34, SP=0xFFFC, PC=0x0050, if_clr=0x04, done 5 clks after accept.
//  2 if=0x1F, ie=0x1A -> idx=1, PC=0x0048; if_clr=0x02 only.
//  3 ime=0, ie=if=0x01, boundary -> stays IDLE, busy=0, wake=1.
//  4 mem_ack held low 3 clks in PUSH_LO -> mem_req/addr/data stable; latency 8 clks.
//  5 SP=0x0000, ie=0x01 (quirk on), dispatch -> 0xFFFF<=PC[15:8] clears IE ->
//    PC=0x0000, no if_clr; quirk off -> PC=0x0040.
//  6 rst asserted in PUSH_HI -> next clk IDLE, all outputs 0, IF/SP unchanged.

Source files
------------

// File: rtl/irq_dispatch_seq_pkg.sv
// Shared types and constants for the SM83 interrupt dispatch sequencer.
// Optional feature macro used by the design: IRQ_CANCEL_QUIRK_EN.
package irq_dispatch_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT0   = 3'd1,
        WAIT1   = 3'd2,
        PUSH_HI = 3'd3,
        PUSH_LO = 3'd4,
        JUMP    = 3'd5
    } irq_state_t;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_LCD    = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam int          N_IRQ_DEF      = 5;
    localparam logic [15:0] IRQ_VEC_BASE   = 16'h0040;
    localparam int          IRQ_VEC_STRIDE = 8;

    function automatic logic [15:0] irq_vec(input logic [15:0] base, input int stride,
                                            input int idx);
        return base + 16'(stride * idx);
    endfunction

endpackage

// File: rtl/irq_dispatch_seq_if.sv
// Bus write port used by the dispatch sequencer to push PC onto the stack.
// Handshake: mem_req/mem_addr/mem_wdata are held stable until a cycle where mem_ack is
// also high; the write is accepted on that rising edge and the master may then move on.
interface irq_dispatch_seq_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;

    modport master (output mem_req, output mem_addr, output mem_wdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, input mem_wdata, output mem_ack);
endinterface

// File: rtl/irq_dispatch_seq_prio_enc.sv
// Lowest-set-bit priority encoder (bit 0 wins); also used by the HALT wake logic.
module irq_prio_enc #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/irq_dispatch_seq.sv
// SM83 interrupt dispatch: push PC (high then low byte), then jump to the vector.
// Build macro IRQ_CANCEL_QUIRK_EN re-samples pending IRQs after the high-byte push.
module irq_dispatch_seq
    import irq_dispatch_seq_pkg::*;
#(
    parameter int          N_IRQ      = N_IRQ_DEF,
    parameter logic [15:0] VEC_BASE   = IRQ_VEC_BASE,
    parameter int          VEC_STRIDE = IRQ_VEC_STRIDE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_boundary,
    input  logic               i_ime,
    input  logic [N_IRQ-1:0]   i_ie_q,
    input  logic [N_IRQ-1:0]   i_if_q,
    input  logic [15:0]        i_r_pc,
    input  logic [15:0]        i_r_sp,
    output logic               o_busy,
    output logic               o_wake,
    output logic               o_ime_clr,
    output logic [N_IRQ-1:0]   o_if_clr,
    output logic               o_wen_pc,
    output logic [15:0]        o_w_pc,
    output logic               o_wen_sp,
    output logic [15:0]        o_w_sp,
    output logic               o_done,
    output irq_state_t         o_state,
    irq_dispatch_seq_if.master bus
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [N_IRQ-1:0] w_pend;
    logic             w_pend_valid;
    logic [IDX_W-1:0] w_pend_idx;
    logic             w_jump_valid;
    logic [IDX_W-1:0] w_jump_idx;
    logic [N_IRQ-1:0] w_jump_onehot;
    logic [15:0]      w_jump_pc;

    irq_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_pc_q;
    logic             r_busy;
    logic             r_ime_clr;
    logic [N_IRQ-1:0] r_if_clr;
    logic             r_wen_pc;
    logic [15:0]      r_w_pc;
    logic             r_wen_sp;
    logic [15:0]      r_w_sp;
    logic             r_done;
    logic             r_mem_req;
    logic [15:0]      r_mem_addr;
    logic [7:0]       r_mem_wdata;
`ifdef IRQ_CANCEL_QUIRK_EN
    logic             r_resample;
    logic             r_cancel;
`endif

    assign w_pend = i_ie_q & i_if_q;
    assign o_wake = |w_pend;

    irq_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_prio_enc (
        .i_req   (w_pend),
        .o_valid (w_pend_valid),
        .o_idx   (w_pend_idx)
    );

    // The jump target comes from the index latched at accept, or, with the quirk, from
    // a re-sample taken in the first PUSH_LO cycle once the high-byte push has landed.
    always_comb begin
`ifdef IRQ_CANCEL_QUIRK_EN
        w_jump_valid = r_resample ? w_pend_valid : !r_cancel;
        w_jump_idx   = r_resample ? w_pend_idx : r_idx;
`else
        w_jump_valid = 1'b1;
        w_jump_idx   = r_idx;
`endif
        w_jump_onehot = w_jump_valid ? (N_IRQ'(1) << w_jump_idx) : '0;
        w_jump_pc     = w_jump_valid ? irq_vec(VEC_BASE, VEC_STRIDE, int'(w_jump_idx))
                                     : 16'h0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_pc_q      <= '0;
            r_busy      <= 1'b0;
            r_ime_clr   <= 1'b0;
            r_if_clr    <= '0;
            r_wen_pc    <= 1'b0;
            r_w_pc      <= '0;
            r_wen_sp    <= 1'b0;
            r_w_sp      <= '0;
            r_done      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef IRQ_CANCEL_QUIRK_EN
            r_resample  <= 1'b0;
            r_cancel    <= 1'b0;
`endif
        end else begin
            r_ime_clr <= 1'b0;
            r_if_clr  <= '0;
            r_wen_pc  <= 1'b0;
            r_wen_sp  <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_boundary && i_ime && w_pend_valid) begin
                        r_state   <= WAIT0;
                        r_idx     <= w_pend_idx;
                        r_pc_q    <= i_r_pc;
                        r_ime_clr <= 1'b1;
                        r_busy    <= 1'b1;
`ifdef IRQ_CANCEL_QUIRK_EN
                        r_resample <= 1'b0;
                        r_cancel   <= 1'b0;
`endif
                    end
                end
                WAIT0: r_state <= WAIT1;
                WAIT1: begin
                    r_state     <= PUSH_HI;
                    r_mem_req   <= 1'b1;
                    r_mem_addr  <= i_r_sp - 16'd1;
                    r_mem_wdata <= r_pc_q[15:8];
                end
                PUSH_HI: begin
                    if (bus.mem_ack) begin
                        r_state     <= PUSH_LO;
                        r_wen_sp    <= 1'b1;
                        r_w_sp      <= r_mem_addr;
                        r_mem_addr  <= r_mem_addr - 16'd1;
                        r_mem_wdata <= r_pc_q[7:0];
`ifdef IRQ_CANCEL_QUIRK_EN
                        r_resample  <= 1'b1;
`endif
                    end
                end
                PUSH_LO: begin
`ifdef IRQ_CANCEL_QUIRK_EN
                    if (r_resample) begin
                        r_resample <= 1'b0;
                        r_idx      <= w_pend_idx;
                        r_cancel   <= !w_pend_valid;
                    end
`endif
                    if (bus.mem_ack) begin
                        r_state     <= JUMP;
                        r_wen_sp    <= 1'b1;
                        r_w_sp      <= r_mem_addr;
                        r_mem_req   <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_wen_pc    <= 1'b1;
                        r_w_pc      <= w_jump_pc;
                        r_if_clr    <= w_jump_onehot;
                        r_done      <= 1'b1;
                    end
                end
                JUMP: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_ime_clr     = r_ime_clr;
    assign o_if_clr      = r_if_clr;
    assign o_wen_pc      = r_wen_pc;
    assign o_w_pc        = r_w_pc;
    assign o_wen_sp      = r_wen_sp;
    assign o_w_sp        = r_w_sp;
    assign o_done        = r_done;
    assign o_state       = r_state;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule
